non_restoring_divider: RTL and testbench

NON_RESTORING_DIVIDER -- requirements
Module: non_restoring_divider

---
 rtl/non_restoring_divider.sv | 81 ++++++++
 tb/tb_non_restoring_divider.sv | 129 ++++++++++++
 2 files changed

// File: rtl/non_restoring_divider.sv
// non_restoring_divider: multi-cycle unsigned X/Y divider (non-restoring) with fixed WIDTH+2 edge latency.
//   clk, rst_n (async, active low), start, X (dividend), Y (divisor) in;
//   Q (quotient), R (zero-extended remainder), busy, done (1-cycle pulse), div_by_zero out.
module non_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH:0]   R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0]   a, a_sh, a_nx, a_fix;
  logic [WIDTH-1:0] qw, qw_nx, m;
  logic [CW-1:0]    cnt;
  logic             last;
  assign last  = cnt == CW'(WIDTH - 1);
  // A is WIDTH+1 bits; the shifted value may wrap, but the add/sub result always lands in [-M, M) so the wrap cancels.
  assign a_sh  = {a[WIDTH-1:0], qw[WIDTH-1]};
  assign a_nx  = a[WIDTH] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
  assign qw_nx = {qw[WIDTH-2:0], ~a_nx[WIDTH]};
  assign a_fix = a[WIDTH] ? a + {1'b0, m} : a;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? CALC : IDLE;
      CALC:    state_nx = last ? CORR : CALC;
      CORR:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // With M = 0 the accumulator just collects X and every quotient bit is 1, giving Q = all ones, R = X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= '0;
      qw          <= '0;
      m           <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= state_nx == CALC || state_nx == CORR;
      done <= state_nx == DONE;
      unique case (state)
        IDLE: if (start) begin
          a   <= '0;
          qw  <= X;
          m   <= Y;
          cnt <= '0;
        end
        CALC: begin
          a   <= a_nx;
          qw  <= qw_nx;
          cnt <= cnt + CW'(1);
        end
        CORR: begin
          a           <= a_fix;
          Q           <= qw;
          R           <= a_fix;
          div_by_zero <= m == '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_non_restoring_divider.sv
// tb_non_restoring_divider: scoreboard bench for non_restoring_divider at WIDTH=4.
module tb_non_restoring_divider;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] X = 0, Y = 0, Q;
  logic [W:0] R;
  logic busy, done, div_by_zero;
  typedef struct packed {
    logic [W-1:0] q;
    logic [W:0]   r;
    logic         z;
  } res_t;
  res_t sb[$];
  res_t last_res = '0;
  int n_cmp = 0, n_err = 0;
  non_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t e;
    if (y == 0) e = '{q: {W{1'b1}}, r: {1'b0, x}, z: 1'b1};
    else        e = '{q: W'(x / y), r: (W+1)'(x % y), z: 1'b0};
    return e;
  endfunction
  // ign: hold start high for part of the computation with other operands; abort: pulse reset mid-CALC.
  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input bit ign, input bit abort);
    int edges;
    res_t e;
    @(negedge clk);
    X = x; Y = y; start = 1;
    sb.push_back(model(x, y));
    @(posedge clk);
    @(negedge clk);
    start = 0;
    X = W'($urandom); Y = W'($urandom);
    edges = 1;
    chk("busy_after_accept", busy, 1);
    while (!done && edges < 20) begin
      if (edges == 3) begin
        chk("q_hold", Q, last_res.q);
        chk("r_hold", R, last_res.r);
        chk("z_hold", div_by_zero, last_res.z);
        if (abort) begin
          rst_n = 0;
          #1;
          chk("rst_q", Q, 0);
          chk("rst_r", R, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_z", div_by_zero, 0);
          sb.delete();
          last_res = '0;
          repeat (2) @(negedge clk);
          rst_n = 1;
          repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
          end
          return;
        end
      end
      start = ign && edges >= 2 && edges < 5;
      if (ign) begin X = W'($urandom); Y = W'($urandom); end
      @(negedge clk);
      edges++;
    end
    start = 0;
    chk("latency", edges, W + 2);
    chk("busy_at_done", busy, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("q_%0d_%0d", x, y), Q, e.q);
      chk($sformatf("r_%0d_%0d", x, y), R, e.r);
      chk($sformatf("z_%0d_%0d", x, y), div_by_zero, e.z);
      last_res = e;
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    if (ign) begin
      repeat (2) begin
        @(negedge clk);
        chk("no_queued_start", busy, 0);
      end
    end
  endtask
  initial begin
    #12;
    chk("reset_q", Q, 0);
    chk("reset_r", R, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_z", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1;
    run(6, 2, 0, 0);
    run(12, 3, 0, 0);
    run(13, 12, 0, 0);
    run(14, 9, 0, 0);
    run(5, 10, 0, 0);
    run(9, 12, 0, 0);
    run(7, 0, 0, 0);
    run(15, 1, 0, 0);
    run(11, 4, 1, 0);
    run(10, 3, 0, 1);
    run(13, 5, 0, 0);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run(W'(x), W'(y), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end
endmodule
